// File: rtl/oled_stream.sv
// oled_stream: byte sequencer feeding the SSD1331 SPI serializer.
// After reset it idles for the panel power-up delay, sends the init commands,
// then repeats forever: window command, then a full RGB565 frame.
// Each pixel is read from the renderer once, in FETCH, and sent as two bytes.
// Every byte goes out over a valid/ready handshake with its D/C flag.
module oled_stream #(
    parameter int PWR_WAIT = 250000,
    parameter int WIDTH    = 96,
    parameter int HEIGHT   = 64
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  byte_out,
    output logic        byte_dc,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic [6:0]  px_x,
    output logic [5:0]  px_y,
    input  logic [15:0] px_color,
    output logic        init_done,
    output logic        frame_done
);

    localparam int               PWR_W    = (PWR_WAIT > 1) ? $clog2(PWR_WAIT + 1) : 1;
    localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(PWR_WAIT - 1);
    localparam logic [3:0]       INIT_LEN = 4'd12;
    localparam logic [3:0]       WIN_LEN  = 4'd6;
    localparam logic [6:0]       X_LAST   = 7'(WIDTH - 1);
    localparam logic [5:0]       Y_LAST   = 6'(HEIGHT - 1);

    typedef enum logic [2:0] {
        S_WAIT_PWR,
        S_INIT,
        S_WIN,
        S_FETCH,
        S_PIX_HI,
        S_PIX_LO,
        S_FRAME_END
    } state_t;

    // SSD1331 init command bytes, in the order they are sent.
    function automatic logic [7:0] init_byte(input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = 8'hAE;
            4'd1:    b = 8'hA0;
            4'd2:    b = 8'h72;
            4'd3:    b = 8'hA1;
            4'd4:    b = 8'h00;
            4'd5:    b = 8'hA2;
            4'd6:    b = 8'h00;
            4'd7:    b = 8'hA4;
            4'd8:    b = 8'hA8;
            4'd9:    b = 8'h3F;
            4'd10:   b = 8'h87;
            4'd11:   b = 8'hAF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Column/row address window covering the whole panel.
    function automatic logic [7:0] win_byte(input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = 8'h15;
            4'd1:    b = 8'h00;
            4'd2:    b = 8'(WIDTH - 1);
            4'd3:    b = 8'h75;
            4'd4:    b = 8'h00;
            4'd5:    b = 8'(HEIGHT - 1);
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t           state_q, state_d;
    logic [PWR_W-1:0] pwr_cnt_q, pwr_cnt_d;
    logic [3:0]       cmd_idx_q, cmd_idx_d;
    logic [7:0]       byte_out_q, byte_out_d;
    logic             byte_dc_q, byte_dc_d;
    logic             byte_valid_q, byte_valid_d;
    logic [6:0]       px_x_q, px_x_d;
    logic [5:0]       px_y_q, px_y_d;
    logic             init_done_q, init_done_d;
    logic             frame_done_q, frame_done_d;
    logic [7:0]       pix_lo_q, pix_lo_d;
    logic             fire;

    assign fire = byte_valid_q && byte_ready;

    // Next-state and next-output logic; a byte is loaded on the edge that
    // enters its state (or on the transfer of the previous byte), so command
    // and pixel bytes can go out back-to-back.
    always_comb begin
        state_d      = state_q;
        pwr_cnt_d    = pwr_cnt_q;
        cmd_idx_d    = cmd_idx_q;
        byte_out_d   = byte_out_q;
        byte_dc_d    = byte_dc_q;
        byte_valid_d = byte_valid_q;
        px_x_d       = px_x_q;
        px_y_d       = px_y_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        pix_lo_d     = pix_lo_q;

        case (state_q)
            S_WAIT_PWR: begin
                if (pwr_cnt_q == PWR_LAST) begin
                    state_d = S_INIT;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + PWR_W'(1);
                end
            end

            S_INIT: begin
                if (!byte_valid_q) begin
                    // First INIT cycle: present the first command.
                    byte_out_d   = init_byte(4'd0);
                    byte_dc_d    = 1'b0;
                    byte_valid_d = 1'b1;
                    cmd_idx_d    = 4'd1;
                end else if (fire) begin
                    if (cmd_idx_q == INIT_LEN) begin
                        init_done_d = 1'b1;
                        state_d     = S_WIN;
                        byte_out_d  = win_byte(4'd0);
                        cmd_idx_d   = 4'd1;
                    end else begin
                        byte_out_d = init_byte(cmd_idx_q);
                        cmd_idx_d  = cmd_idx_q + 4'd1;
                    end
                end
            end

            S_WIN: begin
                if (fire) begin
                    if (cmd_idx_q == WIN_LEN) begin
                        byte_valid_d = 1'b0;
                        cmd_idx_d    = 4'd0;
                        px_x_d       = 7'd0;
                        px_y_d       = 6'd0;
                        state_d      = S_FETCH;
                    end else begin
                        byte_out_d = win_byte(cmd_idx_q);
                        cmd_idx_d  = cmd_idx_q + 4'd1;
                    end
                end
            end

            S_FETCH: begin
                // Single renderer sample per pixel; low byte held until needed.
                byte_out_d   = px_color[15:8];
                pix_lo_d     = px_color[7:0];
                byte_dc_d    = 1'b1;
                byte_valid_d = 1'b1;
                state_d      = S_PIX_HI;
            end

            S_PIX_HI: begin
                if (fire) begin
                    byte_out_d = pix_lo_q;
                    state_d    = S_PIX_LO;
                end
            end

            S_PIX_LO: begin
                if (fire) begin
                    byte_valid_d = 1'b0;
                    if (px_x_q == X_LAST && px_y_q == Y_LAST) begin
                        px_x_d       = 7'd0;
                        px_y_d       = 6'd0;
                        frame_done_d = 1'b1;
                        state_d      = S_FRAME_END;
                    end else begin
                        if (px_x_q == X_LAST) begin
                            px_x_d = 7'd0;
                            px_y_d = px_y_q + 6'd1;
                        end else begin
                            px_x_d = px_x_q + 7'd1;
                        end
                        state_d = S_FETCH;
                    end
                end
            end

            S_FRAME_END: begin
                byte_out_d   = win_byte(4'd0);
                byte_dc_d    = 1'b0;
                byte_valid_d = 1'b1;
                cmd_idx_d    = 4'd1;
                state_d      = S_WIN;
            end

            default: begin
                state_d = S_WAIT_PWR;
            end
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_WAIT_PWR;
            pwr_cnt_q    <= '0;
            cmd_idx_q    <= 4'd0;
            byte_out_q   <= 8'h00;
            byte_dc_q    <= 1'b0;
            byte_valid_q <= 1'b0;
            px_x_q       <= 7'd0;
            px_y_q       <= 6'd0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pwr_cnt_q    <= pwr_cnt_d;
            cmd_idx_q    <= cmd_idx_d;
            byte_out_q   <= byte_out_d;
            byte_dc_q    <= byte_dc_d;
            byte_valid_q <= byte_valid_d;
            px_x_q       <= px_x_d;
            px_y_q       <= px_y_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Latched low colour byte; always written in FETCH before use.
    always_ff @(posedge clk) begin
        pix_lo_q <= pix_lo_d;
    end

    assign byte_out   = byte_out_q;
    assign byte_dc    = byte_dc_q;
    assign byte_valid = byte_valid_q;
    assign px_x       = px_x_q;
    assign px_y       = px_y_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_oled_stream.sv
// Testbench for oled_stream: expected byte stream queued by a reference model,
// compared by an independent monitor on every accepted byte.
module tb_oled_stream;

    localparam int PWR_WAIT = 10;
    localparam int WIDTH    = 96;
    localparam int HEIGHT   = 64;
    localparam int PERIOD   = 6 + 1 + 3 * WIDTH * HEIGHT;

    logic        clk;
    logic        rst;
    logic [7:0]  byte_out;
    logic        byte_dc;
    logic        byte_valid;
    logic        byte_ready;
    logic [6:0]  px_x;
    logic [5:0]  px_y;
    logic [15:0] px_color;
    logic        init_done;
    logic        frame_done;

    oled_stream #(.PWR_WAIT(PWR_WAIT), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_out   (byte_out),
        .byte_dc    (byte_dc),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .px_x       (px_x),
        .px_y       (px_y),
        .px_color   (px_color),
        .init_done  (init_done),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] b;
        logic       dc;
        int         x;
        int         y;
        int         kind;   // 0 init, 1 window, 2 pixel
        logic       last;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   fd_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Renderer picture; first two pixels fixed to pure red and pure green.
    function automatic logic [15:0] color_fn(input int x, input int y);
        if (x == 0 && y == 0) return 16'hF800;
        if (x == 1 && y == 0) return 16'h07E0;
        return 16'((x * 37 + y * 1021 + x * y * 7) ^ 16'hA5C3);
    endfunction

    task automatic push_cmd(input logic [7:0] b, input int kind);
        exp_t e;
        e.b = b; e.dc = 1'b0; e.x = 0; e.y = 0; e.kind = kind; e.last = 1'b0;
        q.push_back(e);
    endtask

    task automatic push_init();
        logic [7:0] tbl [12] = '{8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2,
                                 8'h00, 8'hA4, 8'hA8, 8'h3F, 8'h87, 8'hAF};
        for (int i = 0; i < 12; i++) push_cmd(tbl[i], 0);
    endtask

    task automatic push_frame();
        exp_t e;
        logic [15:0] c;
        push_cmd(8'h15, 1); push_cmd(8'h00, 1); push_cmd(8'(WIDTH - 1), 1);
        push_cmd(8'h75, 1); push_cmd(8'h00, 1); push_cmd(8'(HEIGHT - 1), 1);
        for (int y = 0; y < HEIGHT; y++) begin
            for (int x = 0; x < WIDTH; x++) begin
                c = color_fn(x, y);
                e.dc = 1'b1; e.x = x; e.y = y; e.kind = 2;
                e.b = c[15:8]; e.last = 1'b0;
                q.push_back(e);
                e.b = c[7:0]; e.last = (x == WIDTH - 1 && y == HEIGHT - 1);
                q.push_back(e);
            end
        end
    endtask

    task automatic arm_reset();
        rst = 1'b1;
        q.delete();
        push_init();
        push_frame();
    endtask

    // Renderer: correct colour while no byte is offered, garbage otherwise,
    // so a late resample would corrupt the pixel bytes.
    initial begin
        px_color = 16'h0000;
        forever begin
            @(posedge clk);
            #2;
            px_color = byte_valid ? 16'($urandom) : color_fn(int'(px_x), int'(px_y));
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic       rst_prev = 1'b1;
        logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_dc = 1'b0;
        logic [7:0] prev_byte = 8'h00;
        logic       exp_init = 1'b0, init_pending = 1'b0;
        logic       exp_fd, fd_pending = 1'b0;
        logic       first_seen = 1'b0, full_ready = 1'b1, have_last_fd = 1'b0;
        int         init_cnt = 0, pix_cnt = 0, since = 0, cyc_abs = 0, last_fd = 0;
        exp_t       e;
        forever begin
            @(negedge clk);
            cyc_abs++;
            exp_fd = fd_pending;
            fd_pending = 1'b0;
            if (rst_prev) begin
                chk("rst_valid", 32'(byte_valid), 32'd0);
                chk("rst_byte", 32'(byte_out), 32'd0);
                chk("rst_dc", 32'(byte_dc), 32'd0);
                chk("rst_px_x", 32'(px_x), 32'd0);
                chk("rst_px_y", 32'(px_y), 32'd0);
                chk("rst_init_done", 32'(init_done), 32'd0);
                chk("rst_frame_done", 32'(frame_done), 32'd0);
                exp_init = 1'b0; init_pending = 1'b0; init_cnt = 0; pix_cnt = 0;
                have_last_fd = 1'b0; full_ready = 1'b1; first_seen = 1'b0; since = 0;
            end else begin
                since++;
                if (init_pending) begin
                    exp_init = 1'b1;
                    init_pending = 1'b0;
                end
                chk("init_done", 32'(init_done), 32'(exp_init));
                chk("frame_done", 32'(frame_done), 32'(exp_fd));
                if (!first_seen && byte_valid) begin
                    first_seen = 1'b1;
                    chk("first_valid_cycles", 32'(since), 32'(PWR_WAIT + 1));
                end
                if (prev_valid && !prev_ready) begin
                    chk("hold_valid", 32'(byte_valid), 32'd1);
                    chk("hold_byte", 32'(byte_out), 32'(prev_byte));
                    chk("hold_dc", 32'(byte_dc), 32'(prev_dc));
                end
                if (frame_done) begin
                    chk("fd_valid_low", 32'(byte_valid), 32'd0);
                    chk("frame_pixel_bytes", 32'(pix_cnt), 32'(2 * WIDTH * HEIGHT));
                    if (q.size() == 0) chk("fd_next_win", 32'd0, 32'd1);
                    else chk("fd_next_win", {24'd0, q[0].b}, 32'h15);
                    if (have_last_fd && full_ready)
                        chk("frame_period", 32'(cyc_abs - last_fd), 32'(PERIOD));
                    fd_count++;
                    last_fd = cyc_abs; have_last_fd = 1'b1; full_ready = 1'b1; pix_cnt = 0;
                end
            end
            if (!rst && byte_valid && byte_ready) begin
                if (q.size() == 0) begin
                    chk("sb_underflow", 32'd0, 32'd1);
                end else begin
                    e = q.pop_front();
                    chk("byte", 32'(byte_out), 32'(e.b));
                    chk("dc", 32'(byte_dc), 32'(e.dc));
                    if (e.kind == 2) begin
                        chk("px_x", 32'(px_x), 32'(e.x));
                        chk("px_y", 32'(px_y), 32'(e.y));
                        pix_cnt++;
                    end
                    if (e.kind == 0) begin
                        init_cnt++;
                        if (init_cnt == 12) init_pending = 1'b1;
                    end
                    if (e.last) fd_pending = 1'b1;
                    if (q.size() < 64) push_frame();
                end
            end
            if (byte_valid && !byte_ready) full_ready = 1'b0;
            prev_valid = byte_valid; prev_ready = byte_ready;
            prev_byte = byte_out; prev_dc = byte_dc;
            rst_prev = rst;
        end
    end

    // Stimulus.
    initial begin
        int   n;
        logic hit;
        byte_ready = 1'b1;
        arm_reset();
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Free-running with ready held high: two full frames and the restart.
        n = 0;
        while (fd_count < 2 && n < 40000) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("frames_seen", 32'(fd_count), 32'd2);
        repeat (20) @(posedge clk);
        #2;

        // Random backpressure, then reset while pixel (40,20) is stalled.
        arm_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        hit = 1'b0;
        n = 0;
        while (!hit && n < 30000) begin
            @(posedge clk);
            #2;
            n++;
            if (px_x == 7'd40 && px_y == 6'd20 && byte_valid) begin
                byte_ready = 1'b0;
                arm_reset();
                hit = 1'b1;
            end else begin
                byte_ready = ($urandom_range(0, 3) != 0);
            end
        end
        chk("mid_reset_reached", 32'(hit), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        byte_ready = 1'b1;

        // Restart after the mid-frame reset.
        repeat (300) @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
